fifo_wr_arbiter: RTL

Round-robin, packet-locking arbiter that shares the write port of one fifoasync instance among N requesters in the wr_clk domain. It grants one requester at a time and holds the grant until that requester's packet ends or a burst limit is reached. It tags each written word with the source ID and a last flag so the read side can demultiplex. It backpressures requesters from the FIFO full flag.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_wr_arbiter_if.sv | 33 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its read-side demux.
package fifo_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_LOCK = ST_LOCK
  } state_e;

  // Source-ID width for n requesters (at least one bit)
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Tagged word layout: {id, last, data}; data occupies [dw-1:0]
  function automatic int unsigned last_bit(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned id_lsb(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned id_msb(input int unsigned dw, input int unsigned idw);
    return dw + idw;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle shared by the arbiter and its environment.
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
);
  localparam int unsigned IDW = id_width(N);
  localparam int unsigned FW  = DW + IDW + 1;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [FW-1:0]   fifo_wr_data;
  logic [N-1:0]    grant;
  logic            busy;

  // Requesters and FIFO side
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request after ptr, searching upward modulo N.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Scan from farthest to nearest so the nearest candidate after ptr wins
  always_comb begin : pick
    logic [IDW-1:0] pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      pos = IDW'((32'(ptr) + k) % N);
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locking round-robin arbiter for the write port of one async FIFO.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAXBURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IDW      = id_width(N);
  localparam int unsigned FW       = DW + IDW + 1;
  localparam int unsigned CW       = $clog2(MAXBURST + 1);
  localparam int unsigned LAST_BIT = last_bit(DW);
  localparam int unsigned ID_LSB   = id_lsb(DW);
  localparam int unsigned ID_MSB   = id_msb(DW, IDW);

  state_e         state_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  logic [N-1:0]   pick_gnt;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;

  logic           own_valid;
  logic           own_last;
  logic [DW-1:0]  own_data;
  logic           lock;
  logic           beat;
  logic           rel;
  logic [FW-1:0]  wr_data_c;

  rr_pick #(.N(N)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the current owner's beat through the one-hot grant
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Beat acceptance and release decision
  always_comb begin
    lock = (state_q == S_LOCK);
    beat = lock && own_valid && !bus.fifo_full;
    rel  = beat && (own_last || (cnt_q == CW'(MAXBURST - 1)));
  end

  // Tagged FIFO word; zero while idle
  always_comb begin
    wr_data_c = '0;
    if (lock) begin
      wr_data_c[DW-1:0]          = own_data;
      wr_data_c[LAST_BIT]        = own_last;
      wr_data_c[ID_MSB:ID_LSB]   = id_q;
    end
  end

  // Drive the bus; write path is combinational from the owner's request
  always_comb begin
    bus.req_ready    = (lock && !bus.fifo_full) ? grant_q : '0;
    bus.fifo_wr_en   = beat;
    bus.fifo_wr_data = wr_data_c;
    bus.grant        = grant_q;
    bus.busy         = busy_q;
  end

  // Arbitration FSM with grant, owner id, burst counter and rotation pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(N - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_gnt;
            id_q    <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (rel) begin
            ptr_q   <= id_q;
            grant_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (beat) begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
